// File: rtl/dffrsnq_async_ctrl_seq.sv
// Sequencer for the active-low async clear/preset nets of a dffrsnq flop bank:
// synchronised reset release plus registered, width-guaranteed clear/preset pulses.
module dffrsnq_async_ctrl_seq #(
   parameter int PW_CYC      = 2,
   parameter int SEP_CYC     = 1,
   parameter int SYNC_STAGES = 2
) (
   input  logic CLK,
   input  logic RST,
   input  logic CLR_REQ,
   input  logic SET_REQ,
   output logic BUSY,
   output logic DONE,
   output logic ERR,
   output logic RN_OUT,
   output logic SETN_OUT
);

   localparam int MAX_CYC = (PW_CYC > SEP_CYC) ? PW_CYC : SEP_CYC;
   localparam int CW      = $clog2(MAX_CYC + 1);
   // RN_OUT itself is the last synchroniser stage, so the chain holds one fewer flop.
   localparam int SW      = SYNC_STAGES - 1;
   localparam logic [CW-1:0] PW_LAST  = CW'(PW_CYC - 1);
   localparam logic [CW-1:0] SEP_LAST = CW'((SEP_CYC > 0) ? SEP_CYC - 1 : 0);
   localparam bit NO_SEP = (SEP_CYC == 0);

   typedef enum logic [2:0] {
      S_RST_SYNC = 3'd0,
      S_IDLE     = 3'd1,
      S_CLR_HOLD = 3'd2,
      S_SET_HOLD = 3'd3,
      S_SEP      = 3'd4
   } state_t;

   state_t        state, state_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic [SW-1:0] sync;
   logic          pend, pend_nx;
   logic          rn_nx, setn_nx, busy_nx, done_nx, err_nx;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) sync <= '0;
      else     sync <= (sync << 1) | SW'(1);
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state    <= S_RST_SYNC;
         cnt      <= '0;
         pend     <= 1'b0;
         RN_OUT   <= 1'b0;
         SETN_OUT <= 1'b1;
         BUSY     <= 1'b1;
         DONE     <= 1'b0;
         ERR      <= 1'b0;
      end else begin
         state    <= state_nx;
         cnt      <= cnt_nx;
         pend     <= pend_nx;
         RN_OUT   <= rn_nx;
         SETN_OUT <= setn_nx;
         BUSY     <= busy_nx;
         DONE     <= done_nx;
         ERR      <= err_nx;
      end
   end

   // Requests are level-sampled at each rising edge and accepted only while
   // BUSY is low; anything seen while BUSY is high is dropped, never queued.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      pend_nx  = pend;
      case (state)
         S_RST_SYNC: begin
            if (sync[SW-1]) begin
               cnt_nx   = '0;
               pend_nx  = 1'b0;
               state_nx = NO_SEP ? S_IDLE : S_SEP;
            end
         end
         S_IDLE: begin
            if (CLR_REQ) begin
               cnt_nx   = '0;
               pend_nx  = 1'b1;
               state_nx = S_CLR_HOLD;
            end else if (SET_REQ) begin
               cnt_nx   = '0;
               pend_nx  = 1'b1;
               state_nx = S_SET_HOLD;
            end
         end
         S_CLR_HOLD, S_SET_HOLD: begin
            if (cnt == PW_LAST) begin
               cnt_nx   = '0;
               state_nx = NO_SEP ? S_IDLE : S_SEP;
               if (NO_SEP) pend_nx = 1'b0;
            end else begin
               cnt_nx = cnt + CW'(1);
            end
         end
         S_SEP: begin
            if (cnt == SEP_LAST) begin
               cnt_nx   = '0;
               pend_nx  = 1'b0;
               state_nx = S_IDLE;
            end else begin
               cnt_nx = cnt + CW'(1);
            end
         end
         default: begin
            cnt_nx   = '0;
            pend_nx  = 1'b0;
            state_nx = S_RST_SYNC;
         end
      endcase
   end

   // Output values are decoded from the next state and registered, so the
   // nets to the flop bank change only on a clock edge (or on RST).
   always_comb begin
      rn_nx   = (state_nx != S_CLR_HOLD) && (state_nx != S_RST_SYNC);
      setn_nx = (state_nx != S_SET_HOLD);
      busy_nx = (state_nx != S_IDLE);
      done_nx = pend && (state != S_IDLE) && (state_nx == S_IDLE);
      err_nx  = (state == S_IDLE) && CLR_REQ && SET_REQ;
   end

endmodule

// File: tb/tb_dffrsnq_async_ctrl_seq.sv
// Bench for dffrsnq_async_ctrl_seq: default instance plus a PW_CYC=1/SEP_CYC=0 instance,
// checked by vector table, hand sequences and a timestamp-based reference model.
module tb_dffrsnq_async_ctrl_seq;

   localparam int SYNC = 2;
   localparam int KRST = 0;
   localparam int KCLR = 1;
   localparam int KSET = 2;

   logic CLK = 1'b0;
   logic RST = 1'b0;
   logic clr0 = 1'b0, set0 = 1'b0, clr1 = 1'b0, set1 = 1'b0;
   logic busy0, done0, err0, rn0, setn0;
   logic busy1, done1, err1, rn1, setn1;

   always #5 CLK = ~CLK;

   dffrsnq_async_ctrl_seq #(.PW_CYC(2), .SEP_CYC(1), .SYNC_STAGES(SYNC)) u_dut0 (
      .CLK(CLK), .RST(RST), .CLR_REQ(clr0), .SET_REQ(set0),
      .BUSY(busy0), .DONE(done0), .ERR(err0), .RN_OUT(rn0), .SETN_OUT(setn0)
   );

   dffrsnq_async_ctrl_seq #(.PW_CYC(1), .SEP_CYC(0), .SYNC_STAGES(SYNC)) u_dut1 (
      .CLK(CLK), .RST(RST), .CLR_REQ(clr1), .SET_REQ(set1),
      .BUSY(busy1), .DONE(done1), .ERR(err1), .RN_OUT(rn1), .SETN_OUT(setn1)
   );

   typedef struct {
      logic clr, set;
      logic rn, setn, busy, done, err;
   } vec_t;

   vec_t tv[16];

   int total = 0;
   int bad   = 0;

   // Reference model: each instance remembers when its current sequence was
   // accepted as absolute edge numbers for release and return to idle.
   int   m_pw[2]  = '{2, 1};
   int   m_sep[2] = '{1, 0};
   int   m_edge[2], m_rel[2], m_idle[2], m_kind[2];
   logic m_err[2];
   logic [4:0] exp_q[$];

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_edge[d] = 0;
         m_kind[d] = KRST;
         m_rel[d]  = SYNC;
         m_idle[d] = SYNC + m_sep[d];
         m_err[d]  = 1'b0;
      end
   endtask

   task automatic model_edge(input int d, input logic c, input logic s);
      logic busy_prev;
      busy_prev = (m_edge[d] < m_idle[d]);
      m_edge[d] = m_edge[d] + 1;
      m_err[d]  = 1'b0;
      if (!busy_prev && (c || s)) begin
         m_kind[d] = c ? KCLR : KSET;
         m_rel[d]  = m_edge[d] + m_pw[d];
         m_idle[d] = m_edge[d] + m_pw[d] + m_sep[d];
         m_err[d]  = c && s;
      end
   endtask

   function automatic logic [4:0] model_out(input int d);
      logic rn, setn, busy, done;
      rn   = !(((m_kind[d] == KCLR) || (m_kind[d] == KRST)) && (m_edge[d] < m_rel[d]));
      setn = !((m_kind[d] == KSET) && (m_edge[d] < m_rel[d]));
      busy = (m_edge[d] < m_idle[d]);
      done = (m_edge[d] == m_idle[d]) && (m_kind[d] != KRST);
      return {rn, setn, busy, done, m_err[d]};
   endfunction

   task automatic chk(input string name, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%b required=%b time=%0t", name, act, exp, $time);
      end
   endtask

   task automatic check_dut(input int d);
      logic [4:0] e, a;
      e = exp_q.pop_front();
      a = (d == 0) ? {rn0, setn0, busy0, done0, err0} : {rn1, setn1, busy1, done1, err1};
      chk($sformatf("dut%0d.RN_OUT", d),   a[4], e[4]);
      chk($sformatf("dut%0d.SETN_OUT", d), a[3], e[3]);
      chk($sformatf("dut%0d.BUSY", d),     a[2], e[2]);
      chk($sformatf("dut%0d.DONE", d),     a[1], e[1]);
      chk($sformatf("dut%0d.ERR", d),      a[0], e[0]);
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, ".d0.RN_OUT"}, rn0, 1'b0);
      chk({tag, ".d0.SETN_OUT"}, setn0, 1'b1);
      chk({tag, ".d0.BUSY"}, busy0, 1'b1);
      chk({tag, ".d0.DONE"}, done0, 1'b0);
      chk({tag, ".d0.ERR"}, err0, 1'b0);
      chk({tag, ".d1.RN_OUT"}, rn1, 1'b0);
      chk({tag, ".d1.SETN_OUT"}, setn1, 1'b1);
      chk({tag, ".d1.BUSY"}, busy1, 1'b1);
      chk({tag, ".d1.DONE"}, done1, 1'b0);
      chk({tag, ".d1.ERR"}, err1, 1'b0);
   endtask

   // Entered 1 time unit after a rising edge; returns 1 time unit after the next one.
   task automatic cycle(input logic c0, input logic s0, input logic c1, input logic s1);
      clr0 = c0; set0 = s0; clr1 = c1; set1 = s1;
      @(posedge CLK);
      model_edge(0, c0, s0);
      model_edge(1, c1, s1);
      exp_q.push_back(model_out(0));
      exp_q.push_back(model_out(1));
      #1;
      check_dut(0);
      check_dut(1);
   endtask

   // Reset pulse shorter than one clock period, applied between edges.
   task automatic reset_pulse(input int width);
      RST = 1'b1;
      #1;
      check_reset_vals("async_rst");
      #(width);
      RST = 1'b0;
      model_reset();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      tv[0]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      tv[1]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      tv[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      tv[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      tv[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      tv[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      tv[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      tv[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      tv[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      tv[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      tv[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      tv[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      tv[12] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      tv[13] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      tv[14] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      tv[15] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

      #1 RST = 1'b1;
      #1 check_reset_vals("por");
      #1 RST = 1'b0;
      model_reset();

      // Release, simultaneous requests, request while busy, held request on default instance.
      for (int i = 0; i < 16; i++) begin
         cycle(tv[i].clr, tv[i].set, 1'b0, 1'b0);
         chk($sformatf("vec%0d.RN_OUT", i),   rn0,   tv[i].rn);
         chk($sformatf("vec%0d.SETN_OUT", i), setn0, tv[i].setn);
         chk($sformatf("vec%0d.BUSY", i),     busy0, tv[i].busy);
         chk($sformatf("vec%0d.DONE", i),     done0, tv[i].done);
         chk($sformatf("vec%0d.ERR", i),      err0,  tv[i].err);
      end

      // Reset during SET_HOLD: preset released and clear asserted together, no DONE.
      cycle(1'b0, 1'b1, 1'b0, 1'b0);
      chk("set_hold.SETN_OUT", setn0, 1'b0);
      reset_pulse(2);
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      chk("rst_abort.e1.RN_OUT", rn0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      chk("rst_abort.e2.RN_OUT", rn0, 1'b1);
      chk("rst_abort.e2.BUSY", busy0, 1'b1);
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      chk("rst_abort.e3.BUSY", busy0, 1'b0);
      chk("rst_abort.e3.DONE", done0, 1'b0);

      // PW_CYC=1, SEP_CYC=0 instance with a held clear request.
      reset_pulse(1);
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      chk("sweep.rel.BUSY", busy1, 1'b0);
      cycle(1'b0, 1'b0, 1'b1, 1'b0);
      chk("sweep.acc.RN_OUT", rn1, 1'b0);
      chk("sweep.acc.BUSY", busy1, 1'b1);
      cycle(1'b0, 1'b0, 1'b1, 1'b0);
      chk("sweep.rel.RN_OUT", rn1, 1'b1);
      chk("sweep.rel.DONE", done1, 1'b1);
      chk("sweep.rel.BUSY0", busy1, 1'b0);
      cycle(1'b0, 1'b0, 1'b1, 1'b0);
      chk("sweep.reacc.RN_OUT", rn1, 1'b0);
      chk("sweep.reacc.DONE", done1, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      chk("sweep.rel2.DONE", done1, 1'b1);

      // Randomised requests with occasional short reset pulses.
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 59) == 0) begin
            reset_pulse($urandom_range(1, 5));
         end
         cycle($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
               $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
